// File: rtl/ibex_data_mem_responder.sv
// ibex_data_mem_responder: word memory answering ibex data requests after a fixed latency.
// Define IBEX_DATA_MEM_RESP_INTG_EN to check write-data integrity and drive SECDED read integrity.
module ibex_data_mem_responder #(
    parameter int          MemDepthWords  = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0010_0000,
    parameter int          RespLatency    = 1,
    parameter int          MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [6:0]  data_wdata_intg_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic [6:0]  data_rdata_intg_o,
    output logic        data_err_o,
    input  logic        stall_gnt_i
);
    localparam int          IdxW      = MemDepthWords > 1 ? $clog2(MemDepthWords) : 1;
    localparam logic [31:0] SpanBytes = 32'(MemDepthWords * 4);

    logic [31:0]     mem [MemDepthWords];
    logic [2:0]      inflight;
    logic            pipe_v [RespLatency];
    logic            pipe_e [RespLatency];
    logic [31:0]     pipe_d [RespLatency];
    logic [31:0]     word_addr;
    logic [31:0]     offset;
    logic [IdxW-1:0] idx;
    logic            in_range;
    logic            intg_ok;
    logic            req_err;
    logic            do_write;
    logic            unused_bits;

`ifdef IBEX_DATA_MEM_RESP_INTG_EN
    // Inverted SECDED(39,32) check bits, same as prim_secded_inv_39_32_enc
    function automatic logic [6:0] secded_inv_enc(input logic [31:0] d);
        return {^(d & 32'h9850_5586), ^(d & 32'h2DCC_624C), ^(d & 32'hC2C1_323B),
                ^(d & 32'h3123_4ED1), ^(d & 32'h413D_89AA), ^(d & 32'hDEBA_8050),
                ^(d & 32'h2606_BD25)} ^ 7'h2A;
    endfunction

    assign intg_ok           = data_wdata_intg_i == secded_inv_enc(data_wdata_i);
    assign data_rdata_intg_o = data_rvalid_o ? secded_inv_enc(data_rdata_o) : 7'h00;
    assign unused_bits       = ^{data_addr_i[1:0], offset[1:0], offset[31:IdxW+2]};
`else
    assign intg_ok           = 1'b1;
    assign data_rdata_intg_o = 7'h00;
    assign unused_bits       = ^{data_addr_i[1:0], offset[1:0], offset[31:IdxW+2], data_wdata_intg_i};
`endif

    assign word_addr = {data_addr_i[31:2], 2'b00};
    assign offset    = word_addr - BaseAddr;
    assign in_range  = (word_addr >= BaseAddr) && (offset < SpanBytes);
    assign idx       = offset[IdxW+1:2];
    assign req_err   = ~in_range | (data_we_i & ~intg_ok);
    assign do_write  = data_gnt_o & data_we_i & ~req_err;

    // A retiring response frees a slot in the same cycle, so it may be reused immediately
    assign data_gnt_o = data_req_i & ~stall_gnt_i & ~rst_i &
                        ((inflight < 3'(MaxOutstanding)) | data_rvalid_o);

    assign data_rvalid_o = pipe_v[RespLatency-1];
    assign data_err_o    = pipe_e[RespLatency-1];
    assign data_rdata_o  = pipe_d[RespLatency-1];

    // Byte-masked write in the grant cycle; contents deliberately survive reset
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (do_write && data_be_i[b]) mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
    end

    // Response shift pipeline; empty slots carry zeros so idle outputs are already 0
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < RespLatency; k++) begin
                pipe_v[k] <= 1'b0;
                pipe_e[k] <= 1'b0;
                pipe_d[k] <= '0;
            end
        end else begin
            pipe_v[0] <= data_gnt_o;
            pipe_e[0] <= data_gnt_o & req_err;
            pipe_d[0] <= (data_gnt_o & ~data_we_i & ~req_err) ? mem[idx] : '0;
            for (int k = 1; k < RespLatency; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                pipe_e[k] <= pipe_e[k-1];
                pipe_d[k] <= pipe_d[k-1];
            end
        end
    end

    // Granted-but-unanswered request count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) inflight <= '0;
        else inflight <= inflight + 3'(data_gnt_o) - 3'(data_rvalid_o);
    end
endmodule

// File: tb/tb_ibex_data_mem_responder.sv
// tb_ibex_data_mem_responder: directed table, backpressure/reset sequences and random traffic vs a queue model
module tb_ibex_data_mem_responder;
    localparam int          LAT   = 3;
    localparam int          MAXO  = 2;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, we = 1'b0, stall = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [6:0]  wintg = 7'h0;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;
    logic [6:0]  rintg;

    int errors = 0, checks = 0, cyc = 0;
    logic        s_gnt, s_rv, s_err;
    logic [31:0] s_rdata;

    typedef struct { int due; logic err; logic [31:0] rdata; } resp_t;
    resp_t       q[$];
    logic [31:0] mdl [int];

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        bad;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t tbl [17];

    ibex_data_mem_responder #(
        .MemDepthWords(DEPTH), .BaseAddr(BASE), .RespLatency(LAT), .MaxOutstanding(MAXO)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt), .data_we_i(we),
        .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata), .data_wdata_intg_i(wintg),
        .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_rdata_intg_o(rintg),
        .data_err_o(err), .stall_gnt_i(stall)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input logic [31:0] d);
        return {^(d & 32'h9850_5586), ^(d & 32'h2DCC_624C), ^(d & 32'hC2C1_323B),
                ^(d & 32'h3123_4ED1), ^(d & 32'h413D_89AA), ^(d & 32'hDEBA_8050),
                ^(d & 32'h2606_BD25)} ^ 7'h2A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference behaviour of one granted request, from the current input values
    function automatic resp_t model_access();
        resp_t       r;
        logic [31:0] wa  = {addr[31:2], 2'b00};
        logic        inr = (wa >= BASE) && (wa < BASE + 32'(4 * DEPTH));
        int          wi  = int'((wa - BASE) >> 2);
        logic        bad = 1'b0;
`ifdef IBEX_DATA_MEM_RESP_INTG_EN
        bad = we && (wintg != enc(wdata));
`endif
        r.due   = cyc + LAT;
        r.err   = !inr || bad;
        r.rdata = 32'h0;
        if (!r.err && we) begin
            for (int b = 0; b < 4; b++) if (be[b]) mdl[wi][8*b +: 8] = wdata[8*b +: 8];
        end else if (!r.err) begin
            r.rdata = mdl[wi];
        end
        return r;
    endfunction

    // One clock: sample and check on the falling edge, advance the model, then move past the rising edge
    task automatic cycle();
        logic        eg, ev;
        logic        e_err = 1'b0;
        logic [31:0] e_rdata = 32'h0;
        logic [6:0]  e_intg = 7'h0;
        @(negedge clk);
        s_gnt = gnt; s_rv = rvalid; s_rdata = rdata; s_err = err;
        ev = !rst && q.size() > 0 && q[0].due == cyc;
        eg = !rst && req && !stall && (q.size() < MAXO || ev);
        if (ev) begin
            e_err   = q[0].err;
            e_rdata = q[0].rdata;
        end
`ifdef IBEX_DATA_MEM_RESP_INTG_EN
        e_intg = ev ? enc(e_rdata) : 7'h0;
`endif
        chk("gnt", 32'(gnt), 32'(eg));
        chk("rvalid", 32'(rvalid), 32'(ev));
        chk("rdata", rdata, e_rdata);
        chk("err", 32'(err), 32'(e_err));
        chk("rintg", 32'(rintg), 32'(e_intg));
        if (rst) q.delete();
        else if (ev) void'(q.pop_front());
        if (eg) q.push_back(model_access());
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic txn(input vec_t v);
        int n = 0;
        req = 1'b1; we = v.we; be = v.be; addr = v.addr; wdata = v.wdata;
        wintg = enc(v.wdata) ^ {6'h0, v.bad};
        cycle();
        chk("txn_gnt", 32'(s_gnt), 32'd1);
        req = 1'b0;
        do begin
            cycle();
            n++;
        end while (!s_rv && n < 10);
        chk("txn_latency", n, LAT);
        chk("txn_rdata", s_rdata, v.exp_rdata);
        chk("txn_err", 32'(s_err), 32'(v.exp_err));
    endtask

    initial begin
        logic [7:0] gp, vp;
        int         grants, nv, n;
        tbl[0]  = '{1'b1, 4'hF, 32'h0010_0000, 32'h0102_0304, 1'b0, 32'h0, 1'b0};
        tbl[1]  = '{1'b1, 4'hF, 32'h0010_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, 4'hF, 32'h0010_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0};
        tbl[3]  = '{1'b0, 4'hF, 32'h0010_0013, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0};
        tbl[4]  = '{1'b1, 4'hF, 32'h0010_0020, 32'h1122_3344, 1'b0, 32'h0, 1'b0};
        tbl[5]  = '{1'b1, 4'h5, 32'h0010_0020, 32'hAABB_CCDD, 1'b0, 32'h0, 1'b0};
        tbl[6]  = '{1'b0, 4'hF, 32'h0010_0020, 32'h0, 1'b0, 32'h11BB_33DD, 1'b0};
        tbl[7]  = '{1'b0, 4'hF, 32'h0000_0000, 32'h0, 1'b0, 32'h0, 1'b1};
        tbl[8]  = '{1'b1, 4'hF, 32'h0010_1000, 32'h5555_5555, 1'b0, 32'h0, 1'b1};
        tbl[9]  = '{1'b0, 4'hF, 32'h0010_0000, 32'h0, 1'b0, 32'h0102_0304, 1'b0};
        tbl[10] = '{1'b0, 4'hF, 32'h000F_FFFC, 32'h0, 1'b0, 32'h0, 1'b1};
        tbl[11] = '{1'b1, 4'hF, 32'h0010_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0};
        tbl[12] = '{1'b0, 4'hF, 32'h0010_0FFC, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0};
        tbl[13] = '{1'b1, 4'h0, 32'h0010_0010, 32'h1234_5678, 1'b0, 32'h0, 1'b0};
`ifdef IBEX_DATA_MEM_RESP_INTG_EN
        tbl[14] = '{1'b1, 4'hF, 32'h0010_0010, 32'h0BAD_F00D, 1'b1, 32'h0, 1'b1};
        tbl[15] = '{1'b0, 4'hF, 32'h0010_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0};
`else
        tbl[14] = '{1'b1, 4'hF, 32'h0010_0010, 32'h0BAD_F00D, 1'b1, 32'h0, 1'b0};
        tbl[15] = '{1'b0, 4'hF, 32'h0010_0010, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b0};
`endif
        tbl[16] = '{1'b0, 4'hF, 32'h0010_1000, 32'h0, 1'b0, 32'h0, 1'b1};

        req = 1'b1; addr = BASE;
        cycle();
        chk("reset_gnt", 32'(s_gnt), 32'd0);
        cycle();
        rst = 1'b0; req = 1'b0;
        cycle();

        for (int i = 0; i < 17; i++) txn(tbl[i]);

        gp = '0; vp = '0; grants = 0;
        we = 1'b0; addr = 32'h0010_0010;
        for (int c = 0; c < 8; c++) begin
            req = grants < 4;
            cycle();
            gp[c] = s_gnt;
            vp[c] = s_rv;
            if (s_gnt) grants++;
        end
        req = 1'b0;
        chk("bp_gnt_pattern", 32'(gp), 32'h1B);
        chk("bp_rvalid_pattern", 32'(vp), 32'hD8);

        addr = BASE; req = 1'b1;
        cycle();
        gp[0] = s_gnt;
        cycle();
        gp[1] = s_gnt;
        chk("rst_pre_gnts", 32'(gp[1:0]), 32'h3);
        rst = 1'b1;
        cycle();
        chk("rst_gnt_forced", 32'(s_gnt), 32'd0);
        cycle();
        rst = 1'b0;
        cycle();
        chk("post_rst_gnt", 32'(s_gnt), 32'd1);
        req = 1'b0; nv = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (s_rv) begin
                nv++;
                chk("post_rst_rdata", s_rdata, 32'h0102_0304);
            end
        end
        chk("post_rst_rvalids", nv, 1);

        for (int i = 0; i < 16; i++) begin
            req = 1'b1; we = 1'b1; be = 4'hF; addr = BASE + 32'(4 * i);
            wdata = $urandom; wintg = enc(wdata);
            n = 0;
            do begin
                cycle();
                n++;
            end while (!s_gnt && n < 8);
            chk("init_gnt", 32'(s_gnt), 32'd1);
        end

        for (int i = 0; i < 400; i++) begin
            req   = ($urandom % 10) < 7;
            stall = ($urandom % 5) == 0;
            we    = $urandom % 2;
            be    = 4'($urandom);
            wdata = $urandom;
            wintg = ($urandom % 8 == 0) ? 7'($urandom) : enc(wdata);
            if ($urandom % 8 == 0)
                addr = ($urandom % 2) ? 32'h0010_1000 + 32'($urandom_range(0, 255))
                                      : 32'h000F_FF00 + 32'($urandom_range(0, 255));
            else
                addr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            cycle();
        end
        req = 1'b0; stall = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
